// File: rtl/gbus_wr_dma.sv
// rtl/gbus_wr_dma.sv - descriptor-driven stream-to-gbus write DMA
//
// Copies a source word stream into the cmem of a range of cores over the
// gbus write port. Each job writes cfg_len words into every core from
// cfg_core_start to cfg_core_end inclusive, starting at cfg_cmem_base.
//
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   cfg_vld                        one-cycle descriptor strobe
//   cfg_head_bias/core_start/
//   core_end/cmem_base/len         job descriptor
//   src_data, src_vld, src_rdy     source stream handshake
//   gbus_req, gbus_gnt             bus request / arbiter grant
//   gbus_addr, gbus_wen, gbus_wdata registered gbus write port
//   abort                          synchronous job cancel
//   busy, done, err                status (done/err are one-cycle pulses)

module gbus_wr_dma #(
    parameter int GBUS_DATA_WIDTH      = 32,
    parameter int BUS_CMEM_ADDR_WIDTH  = 13,
    parameter int BUS_CORE_ADDR_WIDTH  = 4,
    parameter int HEAD_SRAM_BIAS_WIDTH = 2,
    parameter int LEN_WIDTH            = 13
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             cfg_vld,
    input  logic [HEAD_SRAM_BIAS_WIDTH-1:0]  cfg_head_bias,
    input  logic [BUS_CORE_ADDR_WIDTH-1:0]   cfg_core_start,
    input  logic [BUS_CORE_ADDR_WIDTH-1:0]   cfg_core_end,
    input  logic [BUS_CMEM_ADDR_WIDTH-1:0]   cfg_cmem_base,
    input  logic [LEN_WIDTH-1:0]             cfg_len,
    input  logic [GBUS_DATA_WIDTH-1:0]       src_data,
    input  logic                             src_vld,
    output logic                             src_rdy,
    output logic                             gbus_req,
    input  logic                             gbus_gnt,
    output logic [HEAD_SRAM_BIAS_WIDTH+BUS_CORE_ADDR_WIDTH+BUS_CMEM_ADDR_WIDTH-1:0] gbus_addr,
    output logic                             gbus_wen,
    output logic [GBUS_DATA_WIDTH-1:0]       gbus_wdata,
    input  logic                             abort,
    output logic                             busy,
    output logic                             done,
    output logic                             err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]                       state;
    logic [HEAD_SRAM_BIAS_WIDTH-1:0]  head_q;
    logic [BUS_CORE_ADDR_WIDTH-1:0]   core_end_q;
    logic [BUS_CORE_ADDR_WIDTH-1:0]   core_idx;
    logic [BUS_CMEM_ADDR_WIDTH-1:0]   base_q;
    logic [LEN_WIDTH-1:0]             len_q;
    logic [LEN_WIDTH-1:0]             word_cnt;
    logic                             err_q;

    logic                             xfer;
    logic                             last_word;
    logic                             last_core;
    logic                             cfg_ok;
    logic [BUS_CMEM_ADDR_WIDTH-1:0]   cmem_addr;

    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign gbus_req = (state == ST_RUN);
    assign err      = err_q;

    // Abort masks the ready so a cancelled cycle never consumes a word.
    assign src_rdy   = gbus_req & gbus_gnt & ~abort;
    assign xfer      = src_rdy & src_vld;
    assign last_word = (word_cnt == len_q - LEN_WIDTH'(1));
    assign last_core = (core_idx == core_end_q);
    assign cfg_ok    = (cfg_core_start <= cfg_core_end);

    // Truncation to the cmem width gives the modulo-2^N wrap for free.
    assign cmem_addr = base_q + BUS_CMEM_ADDR_WIDTH'(word_cnt);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            head_q     <= '0;
            core_end_q <= '0;
            core_idx   <= '0;
            base_q     <= '0;
            len_q      <= '0;
            word_cnt   <= '0;
            err_q      <= 1'b0;
            gbus_wen   <= 1'b0;
            gbus_addr  <= '0;
            gbus_wdata <= '0;
        end else begin
            // A descriptor is rejected if a job is in flight or the core
            // range is reversed; in both cases nothing is latched.
            err_q    <= cfg_vld & (busy | ~cfg_ok);
            gbus_wen <= xfer;
            if (xfer) begin
                gbus_addr  <= {head_q, core_idx, cmem_addr};
                gbus_wdata <= src_data;
            end

            case (state)
                ST_IDLE: begin
                    if (cfg_vld && cfg_ok) begin
                        head_q     <= cfg_head_bias;
                        core_end_q <= cfg_core_end;
                        core_idx   <= cfg_core_start;
                        base_q     <= cfg_cmem_base;
                        len_q      <= cfg_len;
                        word_cnt   <= '0;
                        state      <= (cfg_len == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (xfer) begin
                        if (last_word) begin
                            word_cnt <= '0;
                            // Stop at core_end rather than incrementing, so
                            // core_end = max never wraps the index.
                            if (last_core) begin
                                state <= ST_DONE;
                            end else begin
                                core_idx <= core_idx + BUS_CORE_ADDR_WIDTH'(1);
                            end
                        end else begin
                            word_cnt <= word_cnt + LEN_WIDTH'(1);
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
